// File: rtl/eq_pot_scanner.sv
// Round-robin scanner for the six EQ slide pots through the shared A2D converter.
// Readings collect in shadow registers and are committed together on an audio sample strobe.
module eq_pot_scanner #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vld,
    input  logic        err_clr,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOL_POT,
    output logic        scan_done,
    output logic        timeout_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;

    localparam logic [2:0]  LAST_IDX = 3'd5;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [2:0]  idx;
    logic [15:0] waitCnt;
    logic [7:0]  gapCnt;
    logic [11:0] shadow [6];

    logic cnvDone;
    logic timedOut;
    logic waitExit;
    logic commitNow;
    logic gapDone;

    // Scan order LP, B1, B2, B3, HP, VOL mapped onto the A2D mux inputs.
    function automatic logic [2:0] chanOf(input logic [2:0] i);
        logic [2:0] c;
        case (i)
            3'd0:    c = 3'd1;
            3'd1:    c = 3'd0;
            3'd2:    c = 3'd4;
            3'd3:    c = 3'd2;
            3'd4:    c = 3'd3;
            default: c = 3'd7;
        endcase
        return c;
    endfunction

    // A completion landing on the last timeout cycle counts as a completion.
    assign cnvDone   = (state == WAIT) && cnv_cmplt;
    assign timedOut  = (state == WAIT) && !cnv_cmplt && (waitCnt == TO_LAST);
    assign waitExit  = cnvDone || timedOut;
    assign commitNow = (state == COMMIT) && vld;
    assign gapDone   = (state == GAP) && (gapCnt == GAP_LAST);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (en) nextState = START;
            end
            START: begin
                nextState = WAIT;
            end
            WAIT: begin
                if (waitExit) nextState = (idx == LAST_IDX) ? COMMIT : GAP;
            end
            GAP: begin
                if (gapDone) nextState = en ? START : IDLE;
            end
            COMMIT: begin
                if (vld) nextState = GAP;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            strt_cnv    <= 1'b0;
            chnnl       <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= nextState;
            strt_cnv  <= (nextState == START);
            scan_done <= commitNow;
            // chnnl is loaded on entry to START and then held until the next one.
            if (nextState == START) chnnl <= chanOf(idx);
            if (waitExit && (idx != LAST_IDX)) begin
                idx <= idx + 3'd1;
            end else if (commitNow) begin
                idx <= '0;
            end
            if (timedOut) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            gapCnt  <= '0;
        end else begin
            if (state == START) begin
                waitCnt <= '0;
            end else if ((state == WAIT) && !waitExit) begin
                waitCnt <= waitCnt + 16'd1;
            end
            if ((state == GAP) && !gapDone) begin
                gapCnt <= gapCnt + 8'd1;
            end else begin
                gapCnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
            POT_LP  <= '0;
            POT_B1  <= '0;
            POT_B2  <= '0;
            POT_B3  <= '0;
            POT_HP  <= '0;
            VOL_POT <= '0;
        end else begin
            if (cnvDone) shadow[idx] <= res;
            // All six outputs move on the same edge so band gains and volume stay coherent.
            if (commitNow) begin
                POT_LP  <= shadow[0];
                POT_B1  <= shadow[1];
                POT_B2  <= shadow[2];
                POT_B3  <= shadow[3];
                POT_HP  <= shadow[4];
                VOL_POT <= shadow[5];
            end
        end
    end

endmodule

// File: tb/tb_eq_pot_scanner.sv
// Directed-sequence bench for eq_pot_scanner with a randomized A2D and a reference model
// holding the expected shadow readings, committed pot values and error flag.
module tb_eq_pot_scanner;

    localparam int GAP = 3;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        rst, en, vld, err_clr, cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv, scan_done, timeout_err;
    logic [2:0]  chnnl;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOL_POT;

    eq_pot_scanner #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .vld(vld), .err_clr(err_clr),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res),
        .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3),
        .POT_HP(POT_HP), .VOL_POT(VOL_POT), .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          chanMap [6] = '{1, 0, 4, 2, 3, 7};
    logic [11:0] refShadow [6];
    logic [11:0] refPot [6];
    logic        refErr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkPots(input string tag);
        check({tag, "_LP"},  POT_LP,  refPot[0]);
        check({tag, "_B1"},  POT_B1,  refPot[1]);
        check({tag, "_B2"},  POT_B2,  refPot[2]);
        check({tag, "_B3"},  POT_B3,  refPot[3]);
        check({tag, "_HP"},  POT_HP,  refPot[4]);
        check({tag, "_VOL"}, VOL_POT, refPot[5]);
    endtask

    task automatic waitStrt(input int budget, output bit found, output int n);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (strt_cnv) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    // One conversion for scan slot i: wait for the start pulse, then answer (or withhold).
    task automatic scanStep(input int i, input logic [11:0] val, input int dly, input bit withhold,
                            input int expGap, input bit dropEn, input bit vldAtDone, input bit strayVld);
        bit found;
        int n;
        waitStrt(TO + GAP + 40, found, n);
        check("strt_found", found, 1);
        if (!found) return;
        if (expGap >= 0) check("strt_latency", n, expGap);
        check("chnnl", chnnl, chanMap[i]);
        if (withhold) begin
            for (int k = 1; k <= TO; k++) begin
                tick();
                if (k == 1) check("strt_one_cycle", strt_cnv, 0);
                if (k == TO) check("err_before_timeout", timeout_err, refErr);
            end
            tick();
            refErr = 1'b1;
            check("err_after_timeout", timeout_err, 1);
        end else begin
            for (int k = 1; k <= dly; k++) begin
                tick();
                if (k == 1) check("strt_one_cycle", strt_cnv, 0);
                if (k == 1 && dropEn) en = 1'b0;
                if (k == 1 && strayVld && dly >= 3) vld = 1'b1;
                if (k == 2) vld = 1'b0;
            end
            cnv_cmplt = 1'b1;
            res = val;
            if (vldAtDone) vld = 1'b1;
            tick();
            cnv_cmplt = 1'b0;
            vld = 1'b0;
            res = 12'($urandom_range(0, 4095));
            refShadow[i] = val;
            check("err_after_done", timeout_err, refErr);
            check("no_commit_in_scan", scan_done, 0);
        end
    endtask

    task automatic doCommit(input int waitCyc);
        check("done_before_vld", scan_done, 0);
        checkPots("pot_before_vld");
        for (int k = 0; k < waitCyc; k++) tick();
        checkPots("pot_held");
        vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int j = 0; j < 6; j++) refPot[j] = refShadow[j];
        check("scan_done_pulse", scan_done, 1);
        checkPots("pot_commit");
        tick();
        check("scan_done_end", scan_done, 0);
    endtask

    initial begin
        bit   found;
        int   n;
        rst = 1'b1; en = 1'b0; vld = 1'b0; err_clr = 1'b0; cnv_cmplt = 1'b0; res = '0;
        for (int j = 0; j < 6; j++) begin refShadow[j] = '0; refPot[j] = '0; end
        refErr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkPots("reset");
        check("reset_strt", strt_cnv, 0);
        check("reset_done", scan_done, 0);
        check("reset_err", timeout_err, 0);
        check("reset_chnnl", chnnl, 0);

        // Basic scan with res = 0x100*(chnnl+1).
        en = 1'b1;
        for (int i = 0; i < 6; i++)
            scanStep(i, 12'(256 * (chanMap[i] + 1)), 20, 0, (i == 0) ? 1 : GAP, 0, 0, 0);
        doCommit(30);
        check("basic_lp", POT_LP, 12'h200);
        check("basic_vol", VOL_POT, 12'h800);

        // Randomized scans; the final slot of each also carries a vld that must not commit.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++)
                scanStep(i, 12'($urandom_range(0, 4095)), int'($urandom_range(1, 30)), 0,
                         (i == 0) ? GAP - 1 : GAP, 0, (i == 5), ($urandom_range(0, 1) == 1));
            doCommit(int'($urandom_range(0, 25)));
        end

        // Timeout on B2, tie on HP, error clear.
        scanStep(0, 12'($urandom_range(0, 4095)), 5, 0, GAP - 1, 0, 0, 0);
        scanStep(1, 12'($urandom_range(0, 4095)), 5, 0, GAP, 0, 0, 0);
        scanStep(2, 12'h000, 0, 1, GAP, 0, 0, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        refErr = 1'b0;
        check("err_clr", timeout_err, 0);
        scanStep(3, 12'($urandom_range(0, 4095)), 5, 0, GAP - 1, 0, 0, 0);
        scanStep(4, 12'h5A5, TO, 0, GAP, 0, 0, 0);
        check("tie_no_err", timeout_err, 0);
        scanStep(5, 12'($urandom_range(0, 4095)), 5, 0, GAP, 0, 0, 0);
        doCommit(4);

        // Pause during B1 and resume at B2.
        scanStep(0, 12'($urandom_range(0, 4095)), 6, 0, GAP - 1, 0, 0, 0);
        scanStep(1, 12'($urandom_range(0, 4095)), 6, 0, GAP, 1, 0, 0);
        waitStrt(GAP + 8, found, n);
        check("paused_no_strt", found, 0);
        en = 1'b1;
        scanStep(2, 12'($urandom_range(0, 4095)), 6, 0, 1, 0, 0, 0);
        for (int i = 3; i < 6; i++)
            scanStep(i, 12'($urandom_range(0, 4095)), 6, 0, GAP, 0, 0, 0);
        doCommit(2);

        // Reset while the channel-2 conversion is pending.
        for (int i = 0; i < 3; i++)
            scanStep(i, 12'($urandom_range(1, 4095)), 4, 0, (i == 0) ? GAP - 1 : GAP, 0, 0, 0);
        waitStrt(GAP + 10, found, n);
        check("rst_strt_found", found, 1);
        check("rst_chnnl", chnnl, 2);
        tick();
        tick();
        rst = 1'b1;
        en = 1'b0;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin refShadow[j] = '0; refPot[j] = '0; end
        refErr = 1'b0;
        checkPots("midrst");
        check("midrst_strt", strt_cnv, 0);
        check("midrst_chnnl", chnnl, 0);
        cnv_cmplt = 1'b1;
        res = 12'hABC;
        tick();
        cnv_cmplt = 1'b0;
        waitStrt(10, found, n);
        check("stray_no_strt", found, 0);
        en = 1'b1;
        scanStep(0, 12'h000, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i < 6; i++)
            scanStep(i, 12'($urandom_range(0, 4095)), 3, 0, GAP, 0, 0, 0);
        doCommit(1);
        check("stray_ignored_lp", POT_LP, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eq_pot_scanner.md
# eq_pot_scanner

Sequencer that scans the six equalizer slide pots through the shared A2D converter. It scans in round-robin order, collects the six 12-bit readings in shadow registers, and commits them to the POT_* inputs of the EQ engine. The commit happens all at once, only on an audio sample strobe, so every band scale and the volume change on the same sample boundary. It sits between the A2D SPI interface and the EQ engine. It owns the only path that configures band gains and volume.

## Interface
- GAP_CYC, 4, idle cycles between consecutive conversions; legal range 1..255
- TIMEOUT_CYC, 1024, WAIT cycles allowed for cnv_cmplt before the channel is abandoned; legal range 2..65535

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  scan enable
- vld  in  1  audio sample strobe, one-cycle pulse
- err_clr  in  1  clears timeout_err
- strt_cnv  out  1  start-conversion pulse to the A2D
- chnnl  out  3  A2D channel select
- cnv_cmplt  in  1  conversion-done pulse from the A2D
- res  in  12  conversion result, valid only when cnv_cmplt=1
- POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOL_POT  out  12 each  committed pot values to the EQ engine
- scan_done  out  1  one-cycle pulse marking a commit
- timeout_err  out  1  sticky conversion-timeout flag

## Operation
- Scan index idx runs 0..5. Order and channel map:
  - LP → chnnl 1
  - B1 → chnnl 0
  - B2 → chnnl 4
  - B3 → chnnl 2
  - HP → chnnl 3
  - VOL → chnnl 7
- The block holds six 12-bit shadow registers, one per pot.
- States: IDLE, START, WAIT, GAP, COMMIT.
- IDLE: on en=1, go to START; otherwise stay.
- START: lasts exactly one cycle; go to WAIT. The timeout counter clears.
- WAIT:
  - On cnv_cmplt: shadow[idx] <= res.
  - On timeout (counter = TIMEOUT_CYC-1 without cnv_cmplt): shadow[idx] is unchanged and timeout_err <= 1.
  - If cnv_cmplt and timeout occur in the same cycle, cnv_cmplt wins and timeout_err is not set.
  - After either event: if idx=5, go to COMMIT; otherwise idx <= idx+1 and go to GAP.
- GAP: counts GAP_CYC cycles. Then go to START if en=1, or to IDLE if en=0. The idx value is kept, so a resumed scan continues where it left off.
- COMMIT: waits for vld. On vld, in one edge:
  - all six POT_* outputs <= shadows;
  - scan_done <= 1;
  - idx <= 0;
  - go to GAP.
- en only gates the GAP→START and IDLE→START transitions. A conversion already in progress, or a pending COMMIT, always completes.
- cnv_cmplt outside WAIT is ignored: no shadow write, no state change.
- vld outside COMMIT is ignored. A vld in the same cycle as the final cnv_cmplt does not commit; the commit waits for the next vld.
- timeout_err: set by a timeout, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Arithmetic: POT values are unsigned 12-bit and are passed through unmodified. There is no filtering or scaling.

## Timing
- All outputs are registered.
- strt_cnv is high for exactly the one cycle the FSM is in START.
- chnnl is driven from the START cycle through the cycle of cnv_cmplt or timeout. Outside that window it holds its last value.
- en sampled high in IDLE at edge N → strt_cnv high during cycle N+1.
- cnv_cmplt sampled at edge M (idx<5) → GAP from M to M+GAP_CYC → strt_cnv high during cycle M+GAP_CYC+1, provided en=1.
- vld sampled in COMMIT at edge K → new POT_* values and scan_done=1 are visible after edge K. scan_done lasts exactly one cycle.
- Minimum full-scan period is 6·(2+GAP_CYC) cycles plus the A2D latencies plus the wait for vld.
- Reset, whether idle or mid-scan, takes effect at the next clk edge:
  - state IDLE, idx 0, counters 0;
  - all shadows and POT_* = 0;
  - strt_cnv, scan_done, timeout_err = 0;
  - chnnl = 0.
- A cnv_cmplt arriving after reset, from a conversion started before reset, is ignored because the FSM is in IDLE.

## Test plan
- Basic scan: en=1; a model A2D returns res = 0x100·(chnnl+1) 20 cycles after each strt_cnv; vld every 200 cycles.
  - Required: strt_cnv channel sequence 1,0,4,2,3,7.
  - Required commit on the next vld: POT_LP=0x200, POT_B1=0x100, POT_B2=0x500, POT_B3=0x300, POT_HP=0x400, VOL_POT=0x800.
  - Required: exactly one scan_done pulse per commit.
- Atomic commit: the scan completes and POT_* are still old values until vld. All six POT_* change on the same edge as scan_done.
- Timeout: A2D withholds cnv_cmplt for channel 4 (B2).
  - Required: after TIMEOUT_CYC WAIT cycles, timeout_err=1 and the scan continues with chnnl 2.
  - Required: POT_B2 keeps its previous value at commit.
  - Required: err_clr=1 drops timeout_err on the next edge.
- Timeout tie: cnv_cmplt arrives in exactly cycle TIMEOUT_CYC-1 of WAIT → res is stored and timeout_err stays 0.
- Pause and resume: en deasserted during WAIT for B1.
  - Required: B1 completes, then IDLE after GAP.
  - Required: re-raising en produces strt_cnv with chnnl 4 first.
- Reset mid-WAIT: rst pulsed while the channel-2 conversion is pending, with POT_* nonzero.
  - Required next cycle: all POT_*=0 and strt_cnv=0.
  - Required: a subsequent stray cnv_cmplt is ignored; with en=1 the next strt_cnv uses chnnl 1.
